// File: rtl/mux_nto1_reg.sv
// N-input registered multiplexer with valid/ready handshake, fixed-select or round-robin.
// Optional accepted-transfer counter on port xfer_cnt, enabled by defining MUX_XFER_CNT_EN.
module mux_nto1_reg #(
    parameter  int DWIDTH = 32,
    parameter  int N      = 4,
    parameter  int CNTW   = 16,
    localparam int SELW   = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic [N*DWIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH-1:0]     out_data,
    output logic [SELW-1:0]       out_src
`ifdef MUX_XFER_CNT_EN
    ,
    output logic [CNTW-1:0]       xfer_cnt
`endif
);

    logic [SELW-1:0]   r_rr_ptr;
    logic [N-1:0]      w_grant;
    logic [SELW-1:0]   w_gidx;
    logic              w_found;
    logic              w_space;
    logic              w_accept;
    logic [SELW-1:0]   w_rr_next;
    logic [DWIDTH-1:0] w_gdata;

    always_comb begin
        int v_idx;
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        v_idx   = 0;
        if (!mode) begin
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    w_found = 1'b1;
                    w_gidx  = sel;
                end
            end
        end else begin
            // Scan from the far end so the channel closest to r_rr_ptr wins last.
            for (int k = N - 1; k >= 0; k--) begin
                v_idx = (int'(r_rr_ptr) + k) % N;
                if (in_valid[v_idx]) begin
                    w_found = 1'b1;
                    w_gidx  = SELW'(v_idx);
                end
            end
        end
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_space   = !out_valid || out_ready;
    assign in_ready  = w_grant & {N{w_space && rst_n}};
    assign w_accept  = |(in_valid & in_ready);
    assign w_gdata   = in_data[int'(w_gidx)*DWIDTH +: DWIDTH];
    assign w_rr_next = (int'(w_gidx) == N - 1) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            r_rr_ptr  <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_data  <= w_gdata;
            out_src   <= w_gidx;
            if (mode) begin
                r_rr_ptr <= w_rr_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_XFER_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (w_accept) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: directed scenarios plus random traffic against a behavioural model.
// Also checks xfer_cnt (CNTW=4) when MUX_XFER_CNT_EN is defined.
module tb_mux_nto1_reg;
    localparam int DW   = 32;
    localparam int N    = 4;
    localparam int CNTW = 4;
    localparam int SELW = 2;

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [SELW-1:0]   out_src;
`ifdef MUX_XFER_CNT_EN
    logic [CNTW-1:0]   xfer_cnt;
`endif

    mux_nto1_reg #(.DWIDTH(DW), .N(N), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef MUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: what the consumer should be seeing.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Inputs already driven; check state and in_ready, then advance one clock.
    task automatic cycle(input bit do_chk);
        int g;
        bit acc;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        acc = rst_n && (g >= 0) && (!m_valid || out_ready);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        if (do_chk) begin
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_src", 64'(out_src), 64'(m_src));
`ifdef MUX_XFER_CNT_EN
            chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
        end
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
        end else if (acc) begin
            m_valid = 1;
            m_data  = in_data[g*DW +: DW];
            m_src   = g;
            if (mode) m_ptr = (g + 1) % N;
            m_cnt   = (m_cnt + 1) % (1 << CNTW);
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        in_data[i*DW +: DW] = v;
    endtask

    initial begin
        logic [DW-1:0] held;
        m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
        rst_n = 0; mode = 0; sel = 0; in_valid = 4'hF; out_ready = 1; in_data = '0;

        // Reset with every channel valid: nothing accepted, outputs cleared.
        cycle(0);
        cycle(1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);

        // Fixed select.
        rst_n = 1;
        set_ch(0, 32'hFFFFFFFF); set_ch(1, 32'hEEEEEEEE);
        set_ch(2, 32'h22222222); set_ch(3, 32'h33333333);
        #1;
        chk("ready_after_release", 64'(|in_ready), 64'd1);
        cycle(1);
        chk("fix_sel0_data", 64'(out_data), 64'hFFFFFFFF);
        chk("fix_sel0_src", 64'(out_src), 64'd0);
        sel = 1;
        cycle(1);
        chk("fix_sel1_data", 64'(out_data), 64'hEEEEEEEE);
        chk("fix_sel1_src", 64'(out_src), 64'd1);
        sel = 3; in_valid = 4'b0111;
        cycle(1);
        chk("fix_sel3_none", 64'(out_valid), 64'd0);

        // Round-robin sweep with wrap-around.
        mode = 1; in_valid = 4'hF;
        set_ch(0, 32'h01234567); set_ch(1, 32'hFEDCBA98);
        set_ch(2, 32'hAAAA5555); set_ch(3, 32'h5555AAAA);
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            chk("rr_src_seq", 64'(out_src), 64'(i % N));
        end
        in_valid = 4'b1001;
        cycle(1);
        chk("rr_skip_to3", 64'(out_src), 64'd3);
        cycle(1);
        chk("rr_wrap_to0", 64'(out_src), 64'd0);
        chk("rr_wrap_data", 64'(out_data), 64'h01234567);

        // Back-pressure: held word stays put, nothing accepted.
        in_valid = 4'hF; out_ready = 0;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            chk("stall_data", 64'(out_data), 64'(held));
            chk("stall_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1;
        cycle(1);
        chk("drain_load_valid", 64'(out_valid), 64'd1);
        chk("drain_load_data", 64'(out_data), 64'hFEDCBA98);

        // Reset while stalled: held word dropped, pointer back to 0.
        out_ready = 0;
        cycle(1);
        rst_n = 0;
        cycle(1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        rst_n = 1; out_ready = 1;
        cycle(1);
        chk("midrst_ptr0_src", 64'(out_src), 64'd0);

`ifdef MUX_XFER_CNT_EN
        // 17 accepts on a 4-bit counter, interleaved with stalls.
        rst_n = 0;
        cycle(1);
        rst_n = 1; in_valid = 4'hF;
        for (int i = 0; i < 17; i++) begin
            out_ready = 1;
            cycle(1);
            if (i % 4 == 3) begin
                out_ready = 0;
                cycle(1);
            end
        end
        #1;
        chk("xfer_wrap", 64'(xfer_cnt), 64'd1);
        out_ready = 1;
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 39) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = SELW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) set_ch(c, $urandom);
            cycle(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
